// File: rtl/prgm_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// memory timing constants.
package prgm_loader_pkg;

  localparam int MEM_DEPTH    = 64;
  localparam int WRITE_CYCLES = 3;
  // Read latency of the memory: mem_out is valid after this many cycles,
  // so the verify compare happens in the cycle after that.
  localparam int READ_CYCLES  = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ERASE     = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_WRITE     = 3'd3,
    S_VERIFY    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/mem_op_timer.sv
// 2-bit down-counter timing memory operations. Loading value N gives an
// operation lasting N+1 cycles; expire is high in the last of them.
module mem_op_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic       expire
);

  logic [1:0] cnt_q;
  logic       run_q;

  // Count down from the loaded value; a new load takes priority over expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == 2'd0) run_q <= 1'b0;
      else               cnt_q <= cnt_q - 2'd1;
    end
  end

  assign expire = run_q && (cnt_q == 2'd0);

endmodule

// File: rtl/prgm_loader.sv
// Program loader: erases the 64x8 program memory, then writes a byte stream
// to addresses 0.. using the memory's 3-cycle write timing.
// Optional feature: define PRGM_LOADER_VERIFY_EN to read back and compare
// every byte after its write.
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is high only in WAIT_BYTE and the source must hold
// in_data stable while in_valid is high and no transfer has happened.
module prgm_loader
  import prgm_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] length,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] mem_adrs,
  output logic       mem_erase,
  output logic       mem_mode,
  output logic [7:0] mem_data,
  input  logic [7:0] mem_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] count
);

  state_t     state_q, state_d;
  logic [6:0] len_q;
  logic [6:0] count_inc;
  logic       start_ok, len_bad, xfer, write_end, verify_fail;
  logic       timer_load, timer_expire;
  logic [1:0] timer_val;

  logic       erase_d, mode_d, ready_d, busy_d, done_d, error_d;
  logic [6:0] count_d;
  logic [5:0] adrs_d;
  logic [7:0] data_d;

  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign len_bad   = length > 7'(MEM_DEPTH);
  assign xfer      = (state_q == S_WAIT_BYTE) && in_valid;
  assign write_end = (state_q == S_WRITE) && timer_expire;
  assign count_inc = count + 7'd1;

`ifdef PRGM_LOADER_VERIFY_EN
  assign verify_fail = (state_q == S_VERIFY) && timer_expire && (mem_out != mem_data);
`else
  logic unused_mem_out;
  assign unused_mem_out = ^mem_out;
  assign verify_fail    = 1'b0;
`endif

  mem_op_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = len_bad ? S_DONE : S_ERASE;
      S_ERASE:        state_d = (len_q == 7'd0) ? S_DONE : S_WAIT_BYTE;
      S_WAIT_BYTE:    if (in_valid) state_d = S_WRITE;
      S_WRITE: begin
        if (timer_expire) begin
`ifdef PRGM_LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = (count_inc == len_q) ? S_DONE : S_WAIT_BYTE;
`endif
        end
      end
      S_VERIFY: begin
        if (timer_expire)
          state_d = (verify_fail || (count == len_q)) ? S_DONE : S_WAIT_BYTE;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Timer control: write timing starts on the transfer, read timing on write exit.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = 2'd0;
    if (xfer) begin
      timer_load = 1'b1;
      timer_val  = 2'(WRITE_CYCLES - 1);
    end else if (write_end && (state_d == S_VERIFY)) begin
      timer_load = 1'b1;
      timer_val  = 2'(READ_CYCLES);
    end
  end

  // Output logic: next-cycle output values, so every output leaves a flop.
  always_comb begin
    erase_d = (state_d == S_ERASE);
    mode_d  = (state_d == S_WRITE);
    ready_d = (state_d == S_WAIT_BYTE);
    busy_d  = (state_d == S_ERASE) || (state_d == S_WAIT_BYTE) ||
              (state_d == S_WRITE) || (state_d == S_VERIFY);
    done_d  = (state_d == S_DONE);

    count_d = count;
    if (start_ok)       count_d = 7'd0;
    else if (write_end) count_d = count_inc;

    error_d = error;
    if (start_ok)         error_d = len_bad;
    else if (verify_fail) error_d = 1'b1;

    adrs_d = mem_adrs;
    data_d = mem_data;
    if (xfer) begin
      adrs_d = count[5:0];
      data_d = in_data;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= 7'd0;
      mem_erase <= 1'b0;
      mem_mode  <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= 7'd0;
      mem_adrs  <= 6'd0;
      mem_data  <= 8'd0;
    end else begin
      if (start_ok) len_q <= length;
      mem_erase <= erase_d;
      mem_mode  <= mode_d;
      in_ready  <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      count     <= count_d;
      mem_adrs  <= adrs_d;
      mem_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_prgm_loader.sv
// Testbench for prgm_loader with a behavioural 64x8 memory and a write
// scoreboard. Define PRGM_LOADER_VERIFY_EN to exercise the read-back build.
module tb_prgm_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] length = 7'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, mem_erase, mem_mode, busy, done, error;
  logic [5:0] mem_adrs;
  logic [7:0] mem_data, mem_out;
  logic [6:0] count;

`ifdef PRGM_LOADER_VERIFY_EN
  localparam int PER_BYTE = 7;
`else
  localparam int PER_BYTE = 4;
`endif

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic [7:0]  bmem[64];
  logic [7:0]  stim[64];
  bit          corrupt = 1'b0;
  int          erase_cnt = 0;
  int          write_cnt = 0;
  int          mode_run = 0;
  logic [13:0] wr_cur;

  prgm_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_adrs (mem_adrs),
    .mem_erase(mem_erase),
    .mem_mode (mem_mode),
    .mem_data (mem_data),
    .mem_out  (mem_out),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .count    (count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (mem_erase) begin
      for (int k = 0; k < 64; k++) bmem[k] <= 8'hFF;
    end else if (mem_mode) begin
      bmem[mem_adrs] <= (corrupt && mem_adrs == 6'd2) ? ~mem_data : mem_data;
    end
  end
  assign mem_out = bmem[mem_adrs];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write is one 3-cycle mem_mode run with stable adrs/data,
  // matched in order against the expected write queue.
  always @(negedge clk) begin
    if (reset) begin
      mode_run = 0;
    end else begin
      if (mem_erase) erase_cnt++;
      if (mem_mode) begin
        if (mode_run == 0) begin
          write_cnt++;
          wr_cur = {mem_adrs, mem_data};
          if (exp_q.size() == 0) check("unexpected_write", 32'(wr_cur), 32'hFFFF);
          else check("write_adrs_data", 32'(wr_cur), 32'(exp_q.pop_front()));
        end else begin
          check("write_stable", 32'({mem_adrs, mem_data}), 32'(wr_cur));
        end
        mode_run++;
      end else begin
        if (mode_run != 0) check("write_len", 32'(mode_run), 32'd3);
        mode_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load of `len` bytes from stim[]; `gap` idle cycles follow each
  // accepted byte. cycles = edges after the start edge until done is seen.
  task automatic run_load(input int len, input int gap, input bit mid_start, output int cycles);
    int i, gapc, budget;
    bit rdy;
    i = 0; gapc = 0; budget = 3000; cycles = 0;
    exp_q.delete();
    erase_cnt = 0;
    write_cnt = 0;
    if (len <= 64) for (int k = 0; k < len; k++) exp_q.push_back({6'(k), stim[k]});
    start = 1'b1;
    length = 7'(len);
    tick();
    start = 1'b0;
    while (!done && budget > 0) begin
      if (i < len && gapc == 0) begin
        in_valid = 1'b1;
        in_data  = stim[i];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (mid_start && i == 2 && gapc == 3) begin
        start  = 1'b1;
        length = 7'd1;
      end else begin
        start = 1'b0;
      end
      if (gap >= PER_BYTE && gapc == 1 && i < len) begin
        check("gap_in_ready", 32'(in_ready), 32'd1);
        check("gap_no_write", 32'(mem_mode), 32'd0);
      end
      rdy = in_ready;
      tick();
      cycles++;
      budget--;
      if (in_valid && rdy) begin
        i++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("load_timeout", 32'(budget > 0), 32'd1);
  endtask

  // Reference model of a completed load, from the loader's rules.
  task automatic check_result(input string tag, input int len, input int cycles, input bit chk_cycles);
    bit bad;
    int mism;
    logic [7:0] ref_byte;
    bad = (len > 64);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'(bad));
    check({tag, "_count"}, 32'(count), bad ? 32'd0 : 32'(len));
    check({tag, "_erases"}, 32'(erase_cnt), bad ? 32'd0 : 32'd1);
    check({tag, "_writes"}, 32'(write_cnt), bad ? 32'd0 : 32'(len));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    if (chk_cycles) check({tag, "_cycles"}, 32'(cycles), bad ? 32'd0 : 32'(PER_BYTE * len + 1));
    if (!bad) begin
      mism = 0;
      for (int k = 0; k < 64; k++) begin
        ref_byte = (k < len) ? stim[k] : 8'hFF;
        if (bmem[k] !== ref_byte) mism++;
      end
      check({tag, "_mem_mismatches"}, 32'(mism), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adrs"},  32'(mem_adrs), 32'd0);
    check({tag, "_erase"}, 32'(mem_erase), 32'd0);
    check({tag, "_mode"},  32'(mem_mode), 32'd0);
    check({tag, "_data"},  32'(mem_data), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, len, gap, budget;
    logic [7:0] seq_a[4];
    seq_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // reset
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // four fixed bytes, in_valid held high
    for (int k = 0; k < 4; k++) stim[k] = seq_a[k];
    run_load(4, 0, 1'b0, cyc);
    check_result("four", 4, cyc, 1'b1);

    // full depth, bytes 0x00..0x3F
    for (int k = 0; k < 64; k++) stim[k] = 8'(k);
    run_load(64, 0, 1'b0, cyc);
    check_result("full", 64, cyc, 1'b1);
    check("full_last_adrs", 32'(mem_adrs), 32'd63);

    // zero length: erase only
    run_load(0, 0, 1'b0, cyc);
    check_result("zero", 0, cyc, 1'b1);

    // out of range length: no erase, error
    run_load(65, 0, 1'b0, cyc);
    check_result("over", 65, cyc, 1'b1);

    // a good load after an error clears it
    for (int k = 0; k < 3; k++) stim[k] = 8'($urandom);
    run_load(3, 0, 1'b0, cyc);
    check_result("after_err", 3, cyc, 1'b1);

    // gapped source plus a start pulse mid-load
    for (int k = 0; k < 6; k++) stim[k] = 8'($urandom);
    run_load(6, PER_BYTE + 1, 1'b1, cyc);
    check_result("gapped", 6, cyc, 1'b0);

    // random loads
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 24);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < len; k++) stim[k] = 8'($urandom);
      run_load(len, gap, 1'b0, cyc);
      check_result("random", len, cyc, gap == 0);
    end

    // reset during the second write cycle
    for (int k = 0; k < 3; k++) stim[k] = 8'($urandom);
    exp_q.delete();
    exp_q.push_back({6'd0, stim[0]});
    start = 1'b1;
    length = 7'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = stim[0];
    budget = 20;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("rst_wait_ready", 32'(in_ready), 32'd1);
    tick();               // transfer edge, write cycle 1 follows
    in_valid = 1'b0;
    tick();               // write cycle 2
    check("rst_in_write", 32'(mem_mode), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    tick();
    check("mid_reset_no_write", 32'(mem_mode), 32'd0);
    for (int k = 0; k < 5; k++) stim[k] = 8'($urandom);
    run_load(5, 0, 1'b0, cyc);
    check_result("reload", 5, cyc, 1'b1);

`ifdef PRGM_LOADER_VERIFY_EN
    // read-back mismatch at address 2 stops the load after the third byte
    corrupt = 1'b1;
    for (int k = 0; k < 5; k++) stim[k] = 8'($urandom);
    run_load(5, 0, 1'b0, cyc);
    check("verify_done", 32'(done), 32'd1);
    check("verify_error", 32'(error), 32'd1);
    check("verify_count", 32'(count), 32'd3);
    check("verify_writes", 32'(write_cnt), 32'd3);
    check("verify_cycles", 32'(cyc), 32'(PER_BYTE * 3 + 1));
    exp_q.delete();
    corrupt = 1'b0;
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
